// File: rtl/draw_snake.sv
// draw_snake: snake body storage, movement/collision FSM and colour overlay
// stage that sits directly after draw_background.
//
// Ports:
//   pclk, rst                    pixel clock, synchronous active-high reset
//   hcount_in/vcount_in, *sync_in, *blnk_in, rgb_in
//                                pixel stream from draw_background
//   frame_x/y_inside_grid, number_x/y_grid
//                                playable-area geometry in 16 px grid cells
//   move_tick, dir, grow         step request, requested direction, grow pulse
//   hcount_out/vcount_out, *sync_out, *blnk_out, rgb_out
//                                stream delayed one cycle, snake overlaid
//   head_x, head_y, snake_len    head grid position and current length
//   busy, game_over              FSM in CHECK/MOVE, FSM in DEAD
module draw_snake #(
    parameter int unsigned MAX_LEN    = 32,
    parameter int unsigned START_LEN  = 4,
    parameter int unsigned START_X    = 20,
    parameter int unsigned START_Y    = 20,
    parameter logic [11:0] HEAD_COLOR = 12'h0_4_0,
    parameter logic [11:0] BODY_COLOR = 12'h0_8_0,
    parameter logic [11:0] DEAD_COLOR = 12'hf_0_0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [6:0]  frame_x_inside_grid,
    input  logic [5:0]  frame_y_inside_grid,
    input  logic [6:0]  number_x_grid,
    input  logic [5:0]  number_y_grid,
    input  logic        move_tick,
    input  logic [1:0]  dir,
    input  logic        grow,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [6:0]  head_x,
    output logic [5:0]  head_y,
    output logic [5:0]  snake_len,
    output logic        busy,
    output logic        game_over
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned SEG_W = 13;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MOVE, S_DEAD} state_t;

    state_t             r_state;
    state_t             w_state_nx;

    // Segment i packed as {x[6:0], y[5:0]}; index 0 is the head.
    logic [SEG_W-1:0]   r_seg [MAX_LEN];
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_k;
    logic [LEN_W-1:0]   r_idx;
    logic [1:0]         r_dir;
    logic               r_grow_pending;
    logic [6:0]         r_nx;
    logic [5:0]         r_ny;
    logic               r_busy;
    logic               r_game_over;

    logic [1:0]         w_eff_dir;
    logic [7:0]         w_hx;
    logic [6:0]         w_hy;
    logic [7:0]         w_nx;
    logic [6:0]         w_ny;
    logic [7:0]         w_x_max;
    logic [6:0]         w_y_max;
    logic               w_in_area;
    logic               w_seg_hit;
    logic               w_last;
    logic [SEG_W-1:0]   w_cell;
    logic               w_head_hit;
    logic               w_body_hit;
    logic [11:0]        w_rgb;

    // Next head from the effective direction; one extra bit so that a step
    // past column/row 0 wraps to a large value and lands outside the area.
    always_comb begin
        w_eff_dir = (dir == (r_dir ^ 2'd2)) ? r_dir : dir;
        w_hx      = {1'b0, r_seg[0][12:6]};
        w_hy      = {1'b0, r_seg[0][5:0]};
        w_nx      = w_hx;
        w_ny      = w_hy;
        case (w_eff_dir)
            2'd0:    w_nx = w_hx + 8'd1;
            2'd1:    w_ny = w_hy - 7'd1;
            2'd2:    w_nx = w_hx - 8'd1;
            default: w_ny = w_hy + 7'd1;
        endcase
        w_x_max   = {1'b0, number_x_grid} - {1'b0, frame_x_inside_grid} - 8'd1;
        w_y_max   = {1'b0, number_y_grid} - {1'b0, frame_y_inside_grid} - 7'd1;
        w_in_area = (w_nx >= {1'b0, frame_x_inside_grid}) && (w_nx <= w_x_max) &&
                    (w_ny >= {1'b0, frame_y_inside_grid}) && (w_ny <= w_y_max);
        w_seg_hit = (r_seg[IDX_W'(r_idx)] == {r_nx, r_ny});
        w_last    = (r_idx == (r_k - LEN_W'(1)));
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (move_tick) begin
                    w_state_nx = w_in_area ? S_CHECK : S_DEAD;
                end
            end
            S_CHECK: begin
                if (w_seg_hit) begin
                    w_state_nx = S_DEAD;
                end else if (w_last) begin
                    w_state_nx = S_MOVE;
                end
            end
            S_MOVE:  w_state_nx = S_IDLE;
            S_DEAD:  w_state_nx = S_DEAD;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register; status flags registered from the next state.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_busy      <= (w_state_nx == S_CHECK) || (w_state_nx == S_MOVE);
            r_game_over <= (w_state_nx == S_DEAD);
        end
    end

    // Body array, move bookkeeping and grow request.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                r_seg[i] <= (i < START_LEN) ? {7'(START_X - i), 6'(START_Y)} : '0;
            end
            r_len          <= LEN_W'(START_LEN);
            r_k            <= '0;
            r_idx          <= '0;
            r_dir          <= 2'd0;
            r_grow_pending <= 1'b0;
            r_nx           <= '0;
            r_ny           <= '0;
        end else begin
            if (grow && (r_state != S_DEAD)) begin
                r_grow_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (move_tick) begin
                        r_dir <= w_eff_dir;
                        r_nx  <= w_nx[6:0];
                        r_ny  <= w_ny[5:0];
                        // A pending grow keeps the tail in place, so it must be checked too.
                        r_k   <= r_grow_pending ? r_len : (r_len - LEN_W'(1));
                        r_idx <= '0;
                    end
                end
                S_CHECK: begin
                    if (!w_last) begin
                        r_idx <= r_idx + LEN_W'(1);
                    end
                end
                S_MOVE: begin
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        r_seg[i] <= r_seg[i-1];
                    end
                    r_seg[0] <= {r_nx, r_ny};
                    if (r_grow_pending && (r_len < LEN_W'(MAX_LEN))) begin
                        r_len <= r_len + LEN_W'(1);
                    end
                    // A grow arriving in this cycle survives for the next move.
                    r_grow_pending <= grow;
                end
                default: ;
            endcase
        end
    end

    // Colour selection for the current pixel cell.
    always_comb begin
        w_cell     = {hcount_in[10:4], vcount_in[9:4]};
        w_head_hit = (r_seg[0] == w_cell);
        w_body_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((i < 32'(r_len)) && (r_seg[i] == w_cell)) begin
                w_body_hit = 1'b1;
            end
        end
        w_rgb = rgb_in;
        if (!(hblnk_in || vblnk_in)) begin
            if (w_head_hit) begin
                w_rgb = r_game_over ? DEAD_COLOR : HEAD_COLOR;
            end else if (w_body_hit) begin
                w_rgb = r_game_over ? DEAD_COLOR : BODY_COLOR;
            end
        end
    end

    // Output pipeline stage keeps timing aligned with the overlay.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= w_rgb;
        end
    end

    assign head_x    = r_seg[0][12:6];
    assign head_y    = r_seg[0][5:0];
    assign snake_len = r_len;
    assign busy      = r_busy;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_draw_snake.sv
// Directed bench for draw_snake (MAX_LEN = 5): reset/render, move latency,
// reversal ban, grow and saturation, self and wall collision, reset recovery.
module tb_draw_snake;

    localparam logic [11:0] HEAD = 12'h040;
    localparam logic [11:0] BODY = 12'h080;
    localparam logic [11:0] DEAD = 12'hf00;
    localparam logic [11:0] BG   = 12'h123;

    logic        pclk;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  frame_x_inside_grid;
    logic [5:0]  frame_y_inside_grid;
    logic [6:0]  number_x_grid;
    logic [5:0]  number_y_grid;
    logic        move_tick;
    logic [1:0]  dir;
    logic        grow;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [6:0]  head_x;
    logic [5:0]  head_y;
    logic [5:0]  snake_len;
    logic        busy;
    logic        game_over;

    int nvec = 0;
    int nerr = 0;
    int nb;

    draw_snake #(.MAX_LEN(5)) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .frame_x_inside_grid(frame_x_inside_grid), .frame_y_inside_grid(frame_y_inside_grid),
        .number_x_grid(number_x_grid), .number_y_grid(number_y_grid),
        .move_tick(move_tick), .dir(dir), .grow(grow),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out),
        .head_x(head_x), .head_y(head_y), .snake_len(snake_len),
        .busy(busy), .game_over(game_over)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        step();
        chk(tag, 32'(rgb_out), 32'(exp));
    endtask

    // Issue one tick and count sampled cycles with busy high.
    task automatic do_move(input logic [1:0] d, output int cnt);
        dir       = d;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            step();
        end
        chk("move_bound", 32'(cnt < 50), 32'd1);
    endtask

    initial begin
        rst = 1'b1; move_tick = 1'b0; grow = 1'b0; dir = 2'd0;
        hcount_in = 11'd100; vcount_in = 11'd50;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
        rgb_in = BG;
        frame_x_inside_grid = 7'd13; frame_y_inside_grid = 6'd15;
        number_x_grid = 7'd64; number_y_grid = 6'd48;

        // Reset values
        step(); step();
        chk("rst_rgb",    32'(rgb_out), 32'd0);
        chk("rst_hcount", 32'(hcount_out), 32'd0);
        chk("rst_hsync",  32'(hsync_out), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_over",   32'(game_over), 32'd0);
        chk("rst_head_x", 32'(head_x), 32'd20);
        chk("rst_head_y", 32'(head_y), 32'd20);
        chk("rst_len",    32'(snake_len), 32'd4);
        rst = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;

        // Initial render along row 320
        pix("r_head_lo", 320, 320, HEAD);
        pix("r_head_hi", 335, 320, HEAD);
        pix("r_body_lo", 272, 320, BODY);
        pix("r_body_hi", 319, 320, BODY);
        pix("r_bg_336",  336, 320, BG);
        hsync_in = 1'b1; vsync_in = 1'b1;
        pix("r_empty", 500, 100, BG);
        chk("pt_hcount", 32'(hcount_out), 32'd500);
        chk("pt_vcount", 32'(vcount_out), 32'd100);
        chk("pt_hsync",  32'(hsync_out), 32'd1);
        chk("pt_vsync",  32'(vsync_out), 32'd1);
        hsync_in = 1'b0; vsync_in = 1'b0;
        hcount_in = 11'd320; vcount_in = 11'd320; hblnk_in = 1'b1;
        step();
        chk("blank_rgb",   32'(rgb_out), 32'(BG));
        chk("blank_hblnk", 32'(hblnk_out), 32'd1);

        // Basic move with K = 3
        dir = 2'd0; move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        chk("mv_busy_e0", 32'(busy), 32'd1);
        chk("mv_hx_e0",   32'(head_x), 32'd20);
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("mv_busy_mid", 32'(busy), 32'd1);
            chk("mv_hx_mid",   32'(head_x), 32'd20);
        end
        step();
        chk("mv_busy_e4", 32'(busy), 32'd0);
        chk("mv_hx_e4",   32'(head_x), 32'd21);
        chk("mv_hy_e4",   32'(head_y), 32'd20);
        pix("mv_tail_gone", 272, 320, BG);
        pix("mv_tail_new",  288, 320, BODY);
        pix("mv_head_new",  336, 320, HEAD);

        // Reversal ban: request left while moving right
        do_move(2'd2, nb);
        chk("rev_busy_cnt", 32'(nb), 32'd4);
        chk("rev_hx", 32'(head_x), 32'd22);
        chk("rev_hy", 32'(head_y), 32'd20);

        // Grow: K = 4
        grow = 1'b1; step(); grow = 1'b0;
        do_move(2'd0, nb);
        chk("grow_busy_cnt", 32'(nb), 32'd5);
        chk("grow_len", 32'(snake_len), 32'd5);
        chk("grow_hx",  32'(head_x), 32'd23);

        // Grow at MAX_LEN: K = 5, length saturates, tail moves
        grow = 1'b1; step(); grow = 1'b0;
        do_move(2'd0, nb);
        chk("sat_busy_cnt", 32'(nb), 32'd6);
        chk("sat_len", 32'(snake_len), 32'd5);
        chk("sat_hx",  32'(head_x), 32'd24);
        pix("sat_old_tail", 304, 320, BG);
        pix("sat_tail",     320, 320, BODY);

        // Self collision: up, left, then down into seg[3]
        do_move(2'd1, nb);
        chk("sc1_cnt", 32'(nb), 32'd5);
        chk("sc1_hy",  32'(head_y), 32'd19);
        do_move(2'd2, nb);
        chk("sc2_hx",  32'(head_x), 32'd23);
        dir = 2'd3; move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        chk("sc3_busy_e0", 32'(busy), 32'd1);
        chk("sc3_over_e0", 32'(game_over), 32'd0);
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("sc3_over_mid", 32'(game_over), 32'd0);
        end
        step();
        chk("sc3_over_e4", 32'(game_over), 32'd1);
        chk("sc3_busy_e4", 32'(busy), 32'd0);
        chk("sc3_hx", 32'(head_x), 32'd23);
        chk("sc3_hy", 32'(head_y), 32'd19);
        pix("dead_head",  368, 304, DEAD);
        pix("dead_body",  384, 320, DEAD);
        pix("dead_empty", 480, 400, BG);

        // DEAD ignores tick and grow
        grow = 1'b1; dir = 2'd1; move_tick = 1'b1;
        step();
        grow = 1'b0; move_tick = 1'b0;
        step();
        chk("dead_busy", 32'(busy), 32'd0);
        chk("dead_hy",   32'(head_y), 32'd19);
        chk("dead_len",  32'(snake_len), 32'd5);
        chk("dead_over", 32'(game_over), 32'd1);

        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_over", 32'(game_over), 32'd0);
        chk("rst2_hx",   32'(head_x), 32'd20);
        chk("rst2_len",  32'(snake_len), 32'd4);

        // Wall collision at x = 50
        for (int m = 0; m < 30; m++) begin
            do_move(2'd0, nb);
        end
        chk("wall_pre_hx", 32'(head_x), 32'd50);
        chk("wall_pre_cnt", 32'(nb), 32'd4);
        dir = 2'd0; move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        chk("wall_over_e0", 32'(game_over), 32'd1);
        chk("wall_busy_e0", 32'(busy), 32'd0);
        do_move(2'd3, nb);
        chk("wall_late_cnt", 32'(nb), 32'd0);
        chk("wall_late_hx",  32'(head_x), 32'd50);
        chk("wall_late_hy",  32'(head_y), 32'd20);
        pix("wall_dead_head", 800, 320, DEAD);
        pix("wall_dead_body", 784, 320, DEAD);

        rst = 1'b1; step(); rst = 1'b0;
        chk("rst3_over", 32'(game_over), 32'd0);
        chk("rst3_hx",   32'(head_x), 32'd20);
        chk("rst3_hy",   32'(head_y), 32'd20);

        // Reset in the middle of CHECK
        dir = 2'd3; move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        step(); step(); step();
        chk("midrst_hy", 32'(head_y), 32'd20);
        do_move(2'd3, nb);
        chk("post_cnt", 32'(nb), 32'd4);
        chk("post_hy",  32'(head_y), 32'd21);
        chk("post_hx",  32'(head_x), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/draw_snake.md
# draw_snake

Pixel-pipeline stage placed directly after `draw_background`. It holds the snake body as a register array of grid coordinates and advances it one grid cell per `move_tick`. It checks each move against the frame walls and the snake's own body, then overlays head and body colours on the background RGB stream. Timing signals are re-registered so the next overlay stage stays aligned.

## Interface
Parameters:
- `MAX_LEN`, 32: capacity of the body array, in segments.
- `START_LEN`, 4: length after reset; must satisfy 2 ≤ `START_LEN` ≤ `MAX_LEN`.
- `START_X`, 20: head grid x after reset.
- `START_Y`, 20: head grid y after reset.
- `HEAD_COLOR`, 12'h0_4_0: head colour.
- `BODY_COLOR`, 12'h0_8_0: body colour.
- `DEAD_COLOR`, 12'hf_0_0: colour of every segment while game over.

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in` in 11 each: pixel position from `draw_background`.
- `hsync_in`, `hblnk_in`, `vsync_in`, `vblnk_in` in 1 each: timing from `draw_background`.
- `rgb_in` in 12: background pixel colour.
- `frame_x_inside_grid` in 7: first playable grid column.
- `frame_y_inside_grid` in 6: first playable grid row.
- `number_x_grid` in 7: screen width in grids.
- `number_y_grid` in 6: screen height in grids.
- `move_tick` in 1: single-cycle pulse requesting one step.
- `dir` in 2: requested direction; 0 right, 1 up (y−1), 2 left, 3 down (y+1).
- `grow` in 1: single-cycle pulse; the next completed move lengthens the snake by 1.
- `hcount_out`, `vcount_out` out 11 each: registered copies of the inputs.
- `hsync_out`, `hblnk_out`, `vsync_out`, `vblnk_out` out 1 each: registered copies of the inputs.
- `rgb_out` out 12: composited colour.
- `head_x` out 7, `head_y` out 6: grid position of segment 0.
- `snake_len` out 6: current length.
- `busy` out 1: high while the FSM is in CHECK or MOVE.
- `game_over` out 1: high while the FSM is in DEAD.

## Operation
Geometry:
- Grid size is fixed at 16 px. Pixel cell is `hcount_in[10:4]`, `vcount_in[9:4]`.
- Playable area: x in [`frame_x_inside_grid`, `number_x_grid`−`frame_x_inside_grid`−1], y in [`frame_y_inside_grid`, `number_y_grid`−`frame_y_inside_grid`−1]. With the background defaults this is x 13..50, y 15..32.

Body storage:
- `seg[0..MAX_LEN-1]` holds {x[6:0], y[5:0]}; seg[0] is the head.
- Reset values: seg[i] = (`START_X`−i, `START_Y`) for i < `START_LEN`, all others 0.
- Also on reset: `snake_len` = `START_LEN`, current direction = right, `grow_pending` = 0, state = IDLE.

State machine (IDLE, CHECK, MOVE, DEAD):
- **IDLE, `move_tick` high:**
  - Latch the effective direction: `dir`, unless it is the reverse of the current direction, in which case the current direction is kept.
  - Compute the next head position.
  - If the next head is outside the playable area, go to DEAD.
  - Otherwise latch the check limit K (K = `snake_len` if `grow_pending` is set, else `snake_len`−1), set idx = 0, and go to CHECK.
- **CHECK:**
  - Each cycle compare seg[idx] with the next head.
  - On a match, go to DEAD.
  - If idx = K−1, go to MOVE; otherwise increment idx.
- **MOVE:**
  - seg[i] ← seg[i−1] for i ≥ 1; seg[0] ← next head.
  - If `grow_pending` is set and `snake_len` < `MAX_LEN`, increment `snake_len`.
  - Clear `grow_pending` and return to IDLE.
- **DEAD:** absorbing until `rst`. `move_tick` and `grow` are ignored.

Event rules:
- `move_tick` in any state other than IDLE is dropped.
- `grow` sets `grow_pending` in every state except DEAD.
- If `grow` arrives in the MOVE cycle, the set wins: `grow_pending` stays 1 for the next move.
- At `MAX_LEN`, a pending grow is consumed without lengthening the snake.

Render (one register stage):
- During blanking, `rgb_out` = `rgb_in`.
- Otherwise, if the pixel cell equals seg[0]: `HEAD_COLOR`.
- Else, if it equals any seg[i] with 0 < i < `snake_len`: `BODY_COLOR`.
- Else: `rgb_in`.
- While `game_over` is high, every matched segment uses `DEAD_COLOR`.

## Timing
- Render and pass-through latency: 1 `pclk` cycle. All timing outputs stay aligned with `rgb_out`.
- Reset values: all pass-through outputs and `rgb_out` are 0; `busy` = 0; `game_over` = 0; `head_x`/`head_y` = `START_X`/`START_Y`; `snake_len` = `START_LEN`.
- Move latency: call the edge that samples `move_tick` in IDLE edge 0.
  - `busy` is high from edge 0 to edge K+1.
  - `seg`, `head_x` and `snake_len` update at edge K+1.
  - `busy` falls at edge K+1.
- Wall hit: `game_over` rises at edge 0.
- Self hit: `game_over` rises at the edge of the matching CHECK cycle.
- Segment registers are read by the render path every cycle. A MOVE landing mid-frame is visible from the next pixel; tearing is accepted.
- `rst` in any state, including mid-CHECK, restores all reset values at that edge.

## Test plan
- **Reset and render.** Apply reset, then scan pixel row `vcount` = 320.
  - `hcount` 320..335 → `HEAD_COLOR`.
  - `hcount` 272..319 → `BODY_COLOR`.
  - `hcount` 336 → `rgb_in`.
  - `head_x` = 20, `snake_len` = 4.
- **Basic move and latency.** `dir` = 0, one `move_tick`.
  - `busy` is high for edges 0..3 (K = 3) and falls at edge 4.
  - `head_x` = 21 at edge 4.
  - Cell (17,20) reverts to `rgb_in`.
- **Reversal ban.** Moving right, `dir` = 2, one tick → `head_x` goes 21→22.
- **Grow.** `grow` pulse, then a tick → `snake_len` 4→5; `busy` is high for 5 cycles (K = 4).
  - With `MAX_LEN` = 5, a further grow plus tick leaves `snake_len` = 5.
- **Wall collision.** Head at (50,20) moving right, one tick.
  - `game_over` = 1 at edge 0.
  - Later ticks leave `head_x` = 50.
  - Segments render in `DEAD_COLOR`.
  - `rst` clears `game_over` and restores the start position.
- **Self collision.** Length 5, ticks with `dir` = 1, then 2, then 3.
  - The third move targets seg[3] → `game_over` = 1 in its 4th CHECK cycle.
  - `head_x`/`head_y` are unchanged by that move.
